// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard unit.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  // Operand forward selects
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;

  // ResultSrc encoding that marks a load in Execute
  localparam logic [1:0] RESULT_LOAD = 2'b01;

endpackage

// File: rtl/hazard_unit_forward_sel.sv
// One ALU operand forward select: Memory-stage producer beats Writeback.
module forward_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output logic [1:0] fwd
);

  // Pick the youngest in-flight producer of rs; x0 is never forwarded.
  always_comb begin
    fwd = FWD_NONE;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      fwd = FWD_M;
    end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      fwd = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding, load-use stall, branch flush,
// data-memory wait freeze with timeout flag, and performance counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic [1:0]  ResultSrcE,
  input  logic        PCSrcE,
  input  logic        MemReqM,
  input  logic        MemAckM,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic        mem_err
);

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state_q;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       lw_stall;
  logic       freeze;
  logic       branch_flush;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  forward_sel u_fwd_a (
    .rs          (Rs1E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd         (fwd_a)
  );

  forward_sel u_fwd_b (
    .rs          (Rs2E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd         (fwd_b)
  );

  // Load in Execute whose destination feeds the instruction in Decode.
  assign lw_stall = (ResultSrcE == RESULT_LOAD) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

  // Freeze covers the entry cycle too, so the stall lands before the
  // state register catches up; the ack cycle is already free-running.
  assign freeze = ((state_q == RUN) && MemReqM && !MemAckM) ||
                  ((state_q == MEM_WAIT) && !MemAckM);

  // A taken branch only flushes outside freeze; a held PCSrcE is picked up
  // on the first cycle freeze drops.
  assign branch_flush = !rst && !freeze && PCSrcE;

  // Memory-wait state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state: enter wait on an unacknowledged request, leave on ack.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      RUN:      if (MemReqM && !MemAckM) state_nxt = MEM_WAIT;
      MEM_WAIT: if (MemAckM)             state_nxt = RUN;
      default:                           state_nxt = RUN;
    endcase
  end

  // Stall/flush/forward outputs; reset forces bubbles everywhere.
  always_comb begin
    ForwardAE = fwd_a;
    ForwardBE = fwd_b;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    if (rst) begin
      ForwardAE = FWD_NONE;
      ForwardBE = FWD_NONE;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushW    = 1'b1;
    end else if (freeze) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  // Wait counter clears in RUN and counts MEM_WAIT cycles; the timeout
  // flag is sticky and never influences the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 8'd0;
      mem_err  <= 1'b0;
    end else if (state_q == MEM_WAIT) begin
      wait_cnt <= sat_inc8(wait_cnt);
      if (sat_inc8(wait_cnt) == TIMEOUT) begin
        mem_err <= 1'b1;
      end
    end else begin
      wait_cnt <= 8'd0;
    end
  end

  // Saturating performance counters for stall and branch-flush cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (StallF) begin
        stall_cnt <= sat_inc16(stall_cnt);
      end
      if (branch_flush) begin
        flush_cnt <= sat_inc16(flush_cnt);
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit (MEM_TIMEOUT=4).
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0, RdM = '0, RdW = '0;
  logic        RegWriteM = 1'b0, RegWriteW = 1'b0;
  logic [1:0]  ResultSrcE = 2'b00;
  logic        PCSrcE = 1'b0, MemReqM = 1'b0, MemAckM = 1'b0;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [15:0] stall_cnt, flush_cnt;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_unit #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemAckM(MemAckM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_err(mem_err)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packed view: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
  function automatic logic [15:0] ctl();
    return {9'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
  endfunction

  initial begin
    // Reset with forwarding conditions present: forwards still forced off
    RdM = 5'd5; RegWriteM = 1'b1; Rs1E = 5'd5;
    #1;
    chk("rst_ctl",   ctl(), 16'b0000111);
    chk("rst_fwdA",  {14'd0, ForwardAE}, 16'd0);
    chk("rst_stcnt", stall_cnt, 16'd0);
    chk("rst_flcnt", flush_cnt, 16'd0);
    chk("rst_err",   {15'd0, mem_err}, 16'd0);

    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    // Forward: M and W both match -> M wins
    RdW = 5'd5; RegWriteW = 1'b1; Rs2E = 5'd0;
    #1;
    chk("fwdA_M",    {14'd0, ForwardAE}, 16'd2);
    chk("fwdB_none", {14'd0, ForwardBE}, 16'd0);
    chk("idle_ctl",  ctl(), 16'd0);
    @(negedge clk);
    RdM = 5'd0; Rs2E = 5'd5;
    #1;
    chk("fwdA_W", {14'd0, ForwardAE}, 16'd1);
    chk("fwdB_W", {14'd0, ForwardBE}, 16'd1);
    @(negedge clk);
    RegWriteW = 1'b0;
    #1;
    chk("fwdA_off", {14'd0, ForwardAE}, 16'd0);
    @(negedge clk);
    RdW = 5'd0; RegWriteM = 1'b0; Rs1E = 5'd0; Rs2E = 5'd0;

    // Load-use on Rs2D
    ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
    #1;
    chk("lw_ctl", ctl(), 16'b1100010);
    @(negedge clk);
    chk("lw_stcnt", stall_cnt, 16'd1);
    RdE = 5'd0;
    #1;
    chk("lw_rd0_ctl", ctl(), 16'd0);
    @(negedge clk);
    chk("lw_rd0_stcnt", stall_cnt, 16'd1);

    // Branch with load-use pending: branch wins
    RdE = 5'd7; PCSrcE = 1'b1;
    #1;
    chk("br_ctl", ctl(), 16'b0000110);
    @(negedge clk);
    chk("br_flcnt", flush_cnt, 16'd1);
    chk("br_stcnt", stall_cnt, 16'd1);
    PCSrcE = 1'b0; ResultSrcE = 2'b00; RdE = 5'd0; Rs2D = 5'd0;

    // Memory wait: 3 unacked cycles with a branch and a forward held
    MemReqM = 1'b1; MemAckM = 1'b0; PCSrcE = 1'b1;
    RdM = 5'd5; RegWriteM = 1'b1; Rs1E = 5'd5;
    #1;
    chk("mw_entry_ctl", ctl(), 16'b1111001);
    chk("mw_fwdA",      {14'd0, ForwardAE}, 16'd2);
    @(negedge clk);
    #1;
    chk("mw_c2_ctl", ctl(), 16'b1111001);
    @(negedge clk);
    #1;
    chk("mw_c3_ctl", ctl(), 16'b1111001);
    @(negedge clk);
    chk("mw_stcnt",  stall_cnt, 16'd4);
    chk("mw_flcnt",  flush_cnt, 16'd1);
    MemAckM = 1'b1;
    #1;
    chk("mw_exit_ctl", ctl(), 16'b0000110);
    @(negedge clk);
    MemReqM = 1'b0; MemAckM = 1'b0; PCSrcE = 1'b0;
    RdM = 5'd0; RegWriteM = 1'b0; Rs1E = 5'd0;
    #1;
    chk("mw_after_ctl", ctl(), 16'd0);
    chk("mw_flcnt2",    flush_cnt, 16'd2);
    chk("mw_stcnt2",    stall_cnt, 16'd4);
    chk("mw_err",       {15'd0, mem_err}, 16'd0);

    // Timeout after 4 MEM_WAIT cycles
    MemReqM = 1'b1;
    repeat (4) @(negedge clk);
    chk("to_err_early", {15'd0, mem_err}, 16'd0);
    @(negedge clk);
    chk("to_err_set", {15'd0, mem_err}, 16'd1);
    chk("to_stcnt",   stall_cnt, 16'd9);
    #1;
    chk("to_ctl_frozen", ctl(), 16'b1111001);
    MemAckM = 1'b1;
    @(negedge clk);
    MemReqM = 1'b0; MemAckM = 1'b0;
    #1;
    chk("to_err_sticky", {15'd0, mem_err}, 16'd1);
    chk("to_ctl_run",    ctl(), 16'd0);

    // Reset in the middle of MEM_WAIT
    @(negedge clk);
    MemReqM = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rw_stcnt_pre", stall_cnt, 16'd11);
    #2;
    rst = 1'b1;
    #1;
    chk("rw_ctl",   ctl(), 16'b0000111);
    chk("rw_stcnt", stall_cnt, 16'd0);
    chk("rw_flcnt", flush_cnt, 16'd0);
    chk("rw_err",   {15'd0, mem_err}, 16'd0);
    MemReqM = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rw_run_ctl", ctl(), 16'd0);
    @(negedge clk);
    chk("rw_stcnt_post", stall_cnt, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
